// File: rtl/fault_campaign_ctrl.sv
// Fault-simulation campaign sequencer: walks the FIL fault list, applies up to
// PAT_COUNT patterns per fault with fault dropping, and tallies detections.
module fault_campaign_ctrl #(
    parameter int OUT_BITS  = 1,
    parameter int PAT_COUNT = 64,
    parameter int PAT_W     = 16,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                FIL_END,
    input  logic [OUT_BITS-1:0] CUT_OP,
    input  logic [OUT_BITS-1:0] FF_OP,
    output logic                FIL_INC,
    output logic                FIL_RST,
    output logic                TPG_LOAD,
    output logic                TPG_EN,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    fault_total,
    output logic [CNT_W-1:0]    fault_detected
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FRST   = 3'd1;
    localparam logic [2:0] S_SEED   = 3'd2;
    localparam logic [2:0] S_APPLY  = 3'd3;
    localparam logic [2:0] S_RECORD = 3'd4;
    localparam logic [2:0] S_INC    = 3'd5;
    localparam logic [2:0] S_SETTLE = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic [PAT_W-1:0] LAST_PAT = PAT_W'(PAT_COUNT - 1);

    // Counters stick at all-ones so a long campaign never reports a wrapped value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == {CNT_W{1'b1}}) begin
            return value;
        end else begin
            return value + CNT_W'(1'b1);
        end
    endfunction

    logic [2:0]       state_q,    state_d;
    logic [PAT_W-1:0] pat_cnt_q,  pat_cnt_d;
    logic             hit_q,      hit_d;
    logic [CNT_W-1:0] total_q,    total_d;
    logic [CNT_W-1:0] det_q,      det_d;

    logic             fil_inc_q,  fil_inc_d;
    logic             fil_rst_q,  fil_rst_d;
    logic             tpg_load_q, tpg_load_d;
    logic             tpg_en_q,   tpg_en_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    logic             mismatch_s;
    logic             last_pat_s;
    logic             abort_s;

    // Per-cycle conditions feeding the state machine.
    always_comb begin
        mismatch_s = (CUT_OP != FF_OP);
        last_pat_s = (pat_cnt_q == LAST_PAT);
        abort_s    = abort && (state_q != S_IDLE) && (state_q != S_DONE);
    end

    // Next-state and datapath decode; abort wins over every busy-state transition.
    always_comb begin
        state_d   = state_q;
        pat_cnt_d = pat_cnt_q;
        hit_d     = hit_q;
        total_d   = total_q;
        det_d     = det_q;
        if (abort_s) begin
            state_d = S_DONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        total_d = {CNT_W{1'b0}};
                        det_d   = {CNT_W{1'b0}};
                        state_d = S_FRST;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FRST: begin
                    state_d = S_SEED;
                end
                S_SEED: begin
                    pat_cnt_d = {PAT_W{1'b0}};
                    hit_d     = 1'b0;
                    state_d   = S_APPLY;
                end
                S_APPLY: begin
                    pat_cnt_d = pat_cnt_q + PAT_W'(1'b1);
                    if (mismatch_s) begin
                        hit_d = 1'b1;
                    end else begin
                        hit_d = hit_q;
                    end
                    // Fault dropping: stop on the first observed difference.
                    if (mismatch_s || last_pat_s) begin
                        state_d = S_RECORD;
                    end else begin
                        state_d = S_APPLY;
                    end
                end
                S_RECORD: begin
                    total_d = sat_inc(total_q);
                    if (hit_q) begin
                        det_d = sat_inc(det_q);
                    end else begin
                        det_d = det_q;
                    end
                    if (FIL_END) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_INC;
                    end
                end
                S_INC: begin
                    state_d = S_SETTLE;
                end
                S_SETTLE: begin
                    state_d = S_SEED;
                end
                S_DONE: begin
                    if (!start) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered yet aligned with state_q.
    always_comb begin
        fil_inc_d  = (state_d == S_INC);
        fil_rst_d  = (state_d != S_FRST);
        tpg_load_d = (state_d == S_SEED);
        tpg_en_d   = (state_d == S_APPLY);
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pat_cnt_q <= {PAT_W{1'b0}};
            hit_q     <= 1'b0;
            total_q   <= {CNT_W{1'b0}};
            det_q     <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            pat_cnt_q <= pat_cnt_d;
            hit_q     <= hit_d;
            total_q   <= total_d;
            det_q     <= det_d;
        end
    end

    // Output registers; FIL_RST idles high because the FIL reset is active-low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fil_inc_q  <= 1'b0;
            fil_rst_q  <= 1'b1;
            tpg_load_q <= 1'b0;
            tpg_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            fil_inc_q  <= fil_inc_d;
            fil_rst_q  <= fil_rst_d;
            tpg_load_q <= tpg_load_d;
            tpg_en_q   <= tpg_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign FIL_INC        = fil_inc_q;
    assign FIL_RST        = fil_rst_q;
    assign TPG_LOAD       = tpg_load_q;
    assign TPG_EN         = tpg_en_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign fault_total    = total_q;
    assign fault_detected = det_q;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Bench for fault_campaign_ctrl: a small FIL/TPG model drives the DUT, monitors
// record APPLY run lengths and SEED-to-SEED gaps, and each test compares them to expectations.
module tb_fault_campaign_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort, fil_end;
    logic [0:0] cut_op, ff_op;
    logic       fil_inc, fil_rst, tpg_load, tpg_en, busy, done;
    logic [15:0] fault_total, fault_detected;

    logic       start2, abort2, fil_end2;
    logic [0:0] cut_op2, ff_op2;
    logic       fil_inc2, fil_rst2, tpg_load2, tpg_en2, busy2, done2;
    logic [1:0] fault_total2, fault_detected2;

    int n_tests = 0;
    int n_fail  = 0;

    fault_campaign_ctrl #(.OUT_BITS(1), .PAT_COUNT(4), .PAT_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .FIL_END(fil_end),
        .CUT_OP(cut_op), .FF_OP(ff_op), .FIL_INC(fil_inc), .FIL_RST(fil_rst),
        .TPG_LOAD(tpg_load), .TPG_EN(tpg_en), .busy(busy), .done(done),
        .fault_total(fault_total), .fault_detected(fault_detected)
    );

    fault_campaign_ctrl #(.OUT_BITS(1), .PAT_COUNT(1), .PAT_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .FIL_END(fil_end2),
        .CUT_OP(cut_op2), .FF_OP(ff_op2), .FIL_INC(fil_inc2), .FIL_RST(fil_rst2),
        .TPG_LOAD(tpg_load2), .TPG_EN(tpg_en2), .busy(busy2), .done(done2),
        .fault_total(fault_total2), .fault_detected(fault_detected2)
    );

    // Environment model: fault list index, pattern index and the injected mismatch.
    int nf = 1, mis_f = -1, mis_p = 0, fil_idx = 0, tpg_cnt = 0;
    int nf2 = 1, fil_idx2 = 0;
    always @(posedge clk) begin
        if (!fil_rst) fil_idx <= 0;
        else if (fil_inc) fil_idx <= fil_idx + 1;
        if (tpg_load) tpg_cnt <= 0;
        else if (tpg_en) tpg_cnt <= tpg_cnt + 1;
        if (!fil_rst2) fil_idx2 <= 0;
        else if (fil_inc2) fil_idx2 <= fil_idx2 + 1;
    end
    assign fil_end  = (fil_idx == nf - 1);
    assign cut_op   = (tpg_en && fil_idx == mis_f && tpg_cnt == mis_p - 1) ? ~ff_op : ff_op;
    assign fil_end2 = (fil_idx2 == nf2 - 1);
    assign cut_op2  = tpg_en2 ? ~ff_op2 : ff_op2;

    // Monitors: observed values go to queues, expected values are queued by the tests.
    int cyc = 0, run = 0, run2 = 0, last_load = -1, inc_cnt = 0, frst_cnt = 0, inc_cnt2 = 0;
    int exp_run_q[$], obs_run_q[$], exp_gap_q[$], obs_gap_q[$], exp_run2_q[$], obs_run2_q[$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (fil_inc) inc_cnt <= inc_cnt + 1;
        if (fil_inc2) inc_cnt2 <= inc_cnt2 + 1;
        if (!fil_rst) begin
            frst_cnt  <= frst_cnt + 1;
            last_load <= -1;
        end else if (tpg_load) begin
            if (last_load >= 0) obs_gap_q.push_back(cyc - last_load);
            last_load <= cyc;
        end
        if (tpg_en) run <= run + 1;
        else if (run != 0) begin
            obs_run_q.push_back(run);
            run <= 0;
        end
        if (tpg_en2) run2 <= run2 + 1;
        else if (run2 != 0) begin
            obs_run2_q.push_back(run2);
            run2 <= 0;
        end
    end

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0; ff_op = 1'b0;
        start2 = 1'b0; abort2 = 1'b0; ff_op2 = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({fil_inc, fil_rst, tpg_load, tpg_en, busy, done} !== 6'b010000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 010000", {fil_inc, fil_rst, tpg_load, tpg_en, busy, done});
        end
        n_tests++;
        if (fault_total !== 16'd0 || fault_detected !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", fault_total, fault_detected);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || fil_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b fil_rst=%b expected 0 0 1", busy, done, fil_rst);
        end
    endtask

    task automatic test_nominal();
        int t, o, e, inc0, frst0;
        nf = 3; mis_f = -1; ff_op = 1'b0;
        obs_run_q.delete(); obs_gap_q.delete();
        for (int i = 0; i < 3; i++) exp_run_q.push_back(4);
        for (int i = 0; i < 2; i++) exp_gap_q.push_back(8);
        inc0 = inc_cnt; frst0 = frst_cnt;
        start = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!done && t < 300);
        n_tests++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL nominal_done: got %b expected 1 within 300 cycles", done); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || fault_total !== 16'd3 || fault_detected !== 16'd0) begin
            n_fail++;
            $display("FAIL nominal_hold: got done=%b total=%0d det=%0d expected 1 3 0", done, fault_total, fault_detected);
        end
        n_tests++;
        if (inc_cnt - inc0 !== 2 || frst_cnt - frst0 !== 1) begin
            n_fail++;
            $display("FAIL nominal_pulses: got inc=%0d frst=%0d expected 2 1", inc_cnt - inc0, frst_cnt - frst0);
        end
        start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL nominal_idle: got done=%b busy=%b expected 0 0", done, busy); end
        while (obs_run_q.size() > 0) begin
            o = obs_run_q.pop_front(); e = -1;
            if (exp_run_q.size() > 0) e = exp_run_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL nominal_apply_len: got %0d expected %0d", o, e); end
        end
        while (obs_gap_q.size() > 0) begin
            o = obs_gap_q.pop_front(); e = -1;
            if (exp_gap_q.size() > 0) e = exp_gap_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL nominal_fault_latency: got %0d expected %0d", o, e); end
        end
        n_tests++;
        if (exp_run_q.size() + exp_gap_q.size() != 0) begin
            n_fail++;
            $display("FAIL nominal_missing: got %0d unseen items expected 0", exp_run_q.size() + exp_gap_q.size());
            exp_run_q.delete(); exp_gap_q.delete();
        end
    endtask

    task automatic test_detect(input int faults, input int f, input int p, input int exp_det);
        int t, o, e;
        nf = faults; mis_f = f; mis_p = p; ff_op = 1'b1;
        obs_run_q.delete(); obs_gap_q.delete();
        for (int i = 0; i < faults; i++) begin
            exp_run_q.push_back((i == f) ? p : 4);
            if (i > 0) exp_gap_q.push_back(((i - 1 == f) ? p : 4) + 4);
        end
        start = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!done && t < 300);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (fault_total !== 16'(faults) || fault_detected !== 16'(exp_det)) begin
            n_fail++;
            $display("FAIL detect_counts: got %0d/%0d expected %0d/%0d", fault_total, fault_detected, faults, exp_det);
        end
        while (obs_run_q.size() > 0) begin
            o = obs_run_q.pop_front(); e = -1;
            if (exp_run_q.size() > 0) e = exp_run_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL detect_apply_len: got %0d expected %0d", o, e); end
        end
        while (obs_gap_q.size() > 0) begin
            o = obs_gap_q.pop_front(); e = -1;
            if (exp_gap_q.size() > 0) e = exp_gap_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL detect_fault_latency: got %0d expected %0d", o, e); end
        end
        n_tests++;
        if (exp_run_q.size() + exp_gap_q.size() != 0) begin
            n_fail++;
            $display("FAIL detect_missing: got %0d unseen items expected 0", exp_run_q.size() + exp_gap_q.size());
            exp_run_q.delete(); exp_gap_q.delete();
        end
        ff_op = 1'b0; mis_f = -1;
    endtask

    task automatic test_abort();
        int t, o, e, inc0;
        nf = 3; mis_f = -1;
        obs_run_q.delete();
        exp_run_q.push_back(4);
        exp_run_q.push_back(1);
        inc0 = inc_cnt;
        start = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!(tpg_en && fil_idx == 1) && t < 300);
        abort = 1'b1;
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || tpg_en !== 1'b0 || fil_inc !== 1'b0 || tpg_load !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_done: got done=%b busy=%b en=%b inc=%b load=%b expected 1 0 0 0 0", done, busy, tpg_en, fil_inc, tpg_load);
        end
        n_tests++;
        if (fault_total !== 16'd1 || fault_detected !== 16'd0) begin
            n_fail++;
            $display("FAIL abort_counts: got %0d/%0d expected 1/0", fault_total, fault_detected);
        end
        abort = 1'b0;
        repeat (5) @(negedge clk);
        n_tests++;
        if (inc_cnt - inc0 !== 1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_no_inc: got inc=%0d done=%b expected 1 1", inc_cnt - inc0, done);
        end
        start = 1'b0;
        @(negedge clk);
        while (obs_run_q.size() > 0) begin
            o = obs_run_q.pop_front(); e = -1;
            if (exp_run_q.size() > 0) e = exp_run_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL abort_apply_len: got %0d expected %0d", o, e); end
        end
        n_tests++;
        if (exp_run_q.size() != 0) begin
            n_fail++;
            $display("FAIL abort_missing: got %0d unseen runs expected 0", exp_run_q.size());
            exp_run_q.delete();
        end
    endtask

    task automatic test_fil_end_at_start();
        int t, inc0, frst0;
        nf = 1; mis_f = -1;
        obs_run_q.delete();
        inc0 = inc_cnt; frst0 = frst_cnt;
        start = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!done && t < 300);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (fault_total !== 16'd1 || inc_cnt - inc0 !== 0 || frst_cnt - frst0 !== 1) begin
            n_fail++;
            $display("FAIL fil_end_start: got total=%0d inc=%0d frst=%0d expected 1 0 1", fault_total, inc_cnt - inc0, frst_cnt - frst0);
        end
        n_tests++;
        if (obs_run_q.size() != 1) begin
            n_fail++;
            $display("FAIL fil_end_runs: got %0d expected 1", obs_run_q.size());
        end
        obs_run_q.delete();
    endtask

    task automatic test_reset_mid();
        int t, inc0;
        nf = 3; mis_f = -1;
        inc0 = inc_cnt;
        start = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!fil_inc && t < 300);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || fault_total !== 16'd1) begin
            n_fail++;
            $display("FAIL settle_precond: got busy=%b total=%0d expected 1 1", busy, fault_total);
        end
        rst = 1'b0;
        start = 1'b0;
        #1;
        n_tests++;
        if ({fil_inc, fil_rst, tpg_load, tpg_en, busy, done} !== 6'b010000 || fault_total !== 16'd0 || fault_detected !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b total=%0d det=%0d expected 010000 0 0",
                     {fil_inc, fil_rst, tpg_load, tpg_en, busy, done}, fault_total, fault_detected);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || fil_rst !== 1'b1 || inc_cnt - inc0 !== 1) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got busy=%b done=%b fil_rst=%b inc=%0d expected 0 0 1 1", busy, done, fil_rst, inc_cnt - inc0);
        end
        obs_run_q.delete(); obs_gap_q.delete();
    endtask

    task automatic test_saturate();
        int t, o, e, inc0;
        nf2 = 6;
        obs_run2_q.delete();
        for (int i = 0; i < 6; i++) exp_run2_q.push_back(1);
        inc0 = inc_cnt2;
        start2 = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!done2 && t < 300);
        start2 = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (fault_total2 !== 2'd3 || fault_detected2 !== 2'd3) begin
            n_fail++;
            $display("FAIL saturate_counts: got %0d/%0d expected 3/3", fault_total2, fault_detected2);
        end
        n_tests++;
        if (inc_cnt2 - inc0 !== 5) begin n_fail++; $display("FAIL saturate_inc: got %0d expected 5", inc_cnt2 - inc0); end
        while (obs_run2_q.size() > 0) begin
            o = obs_run2_q.pop_front(); e = -1;
            if (exp_run2_q.size() > 0) e = exp_run2_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL single_pattern_apply: got %0d expected %0d", o, e); end
        end
        n_tests++;
        if (exp_run2_q.size() != 0) begin
            n_fail++;
            $display("FAIL saturate_missing: got %0d unseen runs expected 0", exp_run2_q.size());
            exp_run2_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_detect(3, 1, 2, 1);
        test_detect(2, 0, 4, 1);
        test_abort();
        test_fil_end_at_start();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
